// File: rtl/z16_pkg.sv
// -----------------------------------------------------------------------------
// z16_pkg
// Shared definitions for the Z16 data-memory responder slice.
//   state_t        : responder FSM states (IDLE / WAIT / RESP)
//   WORD_W         : Z16 data word width in bits
//   BYTES_PER_WORD : bytes per memory word (the CPU addresses bytes)
//   isMisaligned() : true when a byte address does not start a word
// -----------------------------------------------------------------------------
package z16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORD_W         = 16;
    localparam int BYTES_PER_WORD = 2;

    // A word access must start on a word boundary; any low byte-offset bit set
    // means the access straddles two words.
    function automatic logic isMisaligned(input logic [WORD_W-1:0] addr);
        return (addr & WORD_W'(BYTES_PER_WORD - 1)) != '0;
    endfunction

endpackage

// File: rtl/z16_sram.sv
// -----------------------------------------------------------------------------
// z16_sram
// Single-port DEPTH_WORDS x 16 RAM with synchronous write and synchronous read.
// Contents are never reset.
//   i_clk   : clock, rising edge
//   i_we    : write enable for this edge
//   i_addr  : word address (AW bits)
//   i_wdata : write data
//   o_rdata : read data, registered copy of the word addressed at the last edge
// -----------------------------------------------------------------------------
module z16_sram
    import z16_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    // Read returns the pre-write contents on a same-edge write; the responder
    // never reads and writes in the same transaction, so this never matters.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/z16_mem_responder.sv
// -----------------------------------------------------------------------------
// z16_mem_responder
// Responder end of the Z16 data-memory interface. Accepts one load or store at
// a time over req/ready, inserts WAIT_CYCLES wait states, then pulses ack for
// one cycle with registered read data and an error flag for misaligned or
// out-of-range byte addresses.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   i_req   : request, fields held stable until accepted
//   i_we    : 1 = store, 0 = load
//   i_addr  : byte address
//   i_wdata : store data
//   o_ready : request can be accepted this cycle
//   o_ack   : one-cycle completion pulse
//   o_rdata : load data, valid with o_ack (zero for stores and errors)
//   o_err   : valid with o_ack, access was misaligned or out of range
// -----------------------------------------------------------------------------
module z16_mem_responder
    import z16_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [WORD_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_ack,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_err
);

    localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_badWait
            $error("z16_mem_responder: WAIT_CYCLES must be 0..15");
        end
        if (DEPTH_WORDS < 1 || DEPTH_WORDS > 32768) begin : g_badDepth
            $error("z16_mem_responder: DEPTH_WORDS must be 1..32768");
        end
    endgenerate

    state_t            r_state;
    logic [3:0]        r_count;
    logic              r_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_ready;
    logic              r_ack;
    logic              r_err;
    logic              r_rdSel;

    logic              w_txWe;
    logic [WORD_W-1:0] w_txAddr;
    logic [WORD_W-1:0] w_txWdata;
    logic              w_outOfRange;
    logic              w_txErr;
    logic              w_enterResp;
    logic              w_ramWe;
    logic [WORD_W-1:0] w_ramRdata;

    // With zero wait states the RESP-entry edge is the accept edge itself, so
    // the transaction fields come straight from the inputs while idle and from
    // the latched copies otherwise.
    assign w_txWe    = (r_state == ST_IDLE) ? i_we    : r_we;
    assign w_txAddr  = (r_state == ST_IDLE) ? i_addr  : r_addr;
    assign w_txWdata = (r_state == ST_IDLE) ? i_wdata : r_wdata;

    // Addresses beyond the array flag an error rather than aliasing.
    assign w_outOfRange = ({17'd0, w_txAddr[WORD_W-1:1]} >= DEPTH_LIMIT);
    assign w_txErr      = isMisaligned(w_txAddr) | w_outOfRange;

    assign w_enterResp = ((r_state == ST_IDLE) && i_req && (WAIT_CYCLES == 0)) ||
                         ((r_state == ST_WAIT) && (r_count == 4'd1));

    // Reset has priority: a store whose RESP-entry edge coincides with reset
    // is abandoned and must not reach the array.
    assign w_ramWe = i_rst_n && w_enterResp && w_txWe && !w_txErr;

    z16_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .i_clk   (i_clk),
        .i_we    (w_ramWe),
        .i_addr  (w_txAddr[AW:1]),
        .i_wdata (w_txWdata),
        .o_rdata (w_ramRdata)
    );

    // Responder FSM. The SRAM read register captures the addressed word on the
    // RESP-entry edge; r_rdSel decides whether that word is presented or the
    // data bus is held at zero (stores, errors, and outside RESP).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdSel <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_count <= WAIT_LOAD;
                        r_ready <= 1'b0;
                        if (w_enterResp) begin
                            r_state <= ST_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= w_txErr;
                            r_rdSel <= !w_txWe && !w_txErr;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (w_enterResp) begin
                        r_state <= ST_RESP;
                        r_ack   <= 1'b1;
                        r_err   <= w_txErr;
                        r_rdSel <= !w_txWe && !w_txErr;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdSel <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdSel <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_rdata = r_rdSel ? w_ramRdata : '0;

endmodule

// File: tb/tb_z16_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_z16_mem_responder
// Scoreboard bench for z16_mem_responder. Two instances: dut2 with the default
// two wait states (directed plus random traffic) and dut0 with no wait states
// (back-to-back requests). Expected responses come from a byte-addressed
// associative-array memory model and are queued at accept time; per-instance
// monitors pop and compare whenever o_ack is high.
// -----------------------------------------------------------------------------
module tb_z16_mem_responder;

    localparam int DEPTH = 256;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        bit          checkData;
        int          ackCycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req2 = 1'b0, we2 = 1'b0;
    logic [15:0] addr2 = '0, wdata2 = '0;
    logic        ready2, ack2, err2;
    logic [15:0] rdata2;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [15:0] addr0 = '0, wdata0 = '0;
    logic        ready0, ack0, err0;
    logic [15:0] rdata0;

    int          cycleCount = 0;
    int          testsRun = 0;
    int          failCount = 0;
    int          acks0 = 0;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [15:0] model2[int];
    logic [15:0] model0[int];

    z16_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req2), .i_we(we2),
        .i_addr(addr2), .i_wdata(wdata2), .o_ready(ready2), .o_ack(ack2),
        .o_rdata(rdata2), .o_err(err2)
    );

    z16_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_we(we0),
        .i_addr(addr0), .i_wdata(wdata0), .o_ready(ready0), .o_ack(ack0),
        .o_rdata(rdata0), .o_err(err0)
    );

    // Free-running clock and edge counter used to time acks.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Byte-level view of the memory map: words start at even bytes and the
    // last legal byte address is 2*DEPTH-2.
    function automatic bit modelErr(input logic [15:0] addr);
        return (int'(addr) % 2 != 0) || (int'(addr) > 2 * DEPTH - 2);
    endfunction

    function automatic exp_t predict(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                                     input int ackCycle, input bit useModel0);
        exp_t e;
        e.err       = modelErr(addr);
        e.ackCycle  = ackCycle;
        e.rdata     = 16'h0000;
        e.checkData = 1'b1;
        if (!we && !e.err) begin
            if (useModel0) begin
                e.checkData = model0.exists(int'(addr));
                if (e.checkData) e.rdata = model0[int'(addr)];
            end else begin
                e.checkData = model2.exists(int'(addr));
                if (e.checkData) e.rdata = model2[int'(addr)];
            end
        end
        return e;
    endfunction

    // Monitor for dut2: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ack2 !== 1'b0) begin
            if (q2.size() == 0) begin
                checkOutput("dut2UnexpectedAck", 32'(ack2), 32'd0);
            end else begin
                e = q2.pop_front();
                checkOutput("dut2Err", 32'(err2), 32'(e.err));
                checkOutput("dut2AckCycle", 32'(cycleCount), 32'(e.ackCycle));
                if (e.checkData) checkOutput("dut2Rdata", 32'(rdata2), 32'(e.rdata));
            end
        end
    end

    // Monitor for dut0 (no wait states).
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ack0 !== 1'b0) begin
            acks0++;
            if (q0.size() == 0) begin
                checkOutput("dut0UnexpectedAck", 32'(ack0), 32'd0);
            end else begin
                e = q0.pop_front();
                checkOutput("dut0Err", 32'(err0), 32'(e.err));
                checkOutput("dut0AckCycle", 32'(cycleCount), 32'(e.ackCycle));
                if (e.checkData) checkOutput("dut0Rdata", 32'(rdata0), 32'(e.rdata));
            end
        end
    end

    // One transaction on dut2. glitch: pulse a different request during the
    // busy window. abandon: reset the block while the transaction is waiting.
    task automatic applyStimulus(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                                 input bit glitch, input bit abandon);
        int waitCnt;
        int acceptCycle;
        exp_t e;
        waitCnt = 0;
        @(negedge clk);
        while (ready2 !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (ready2 !== 1'b1) begin
            checkOutput("dut2ReadyTimeout", 32'(ready2), 32'd1);
            return;
        end
        req2 = 1'b1; we2 = we; addr2 = addr; wdata2 = wdata;
        @(posedge clk);
        #1;
        acceptCycle = cycleCount;
        // Scramble the fields: nothing may be re-sampled after accept.
        req2 = 1'b0; we2 = 1'($urandom); addr2 = 16'($urandom); wdata2 = 16'($urandom);
        if (!abandon) begin
            e = predict(we, addr, wdata, acceptCycle + 2, 1'b0);
            q2.push_back(e);
            if (we && !e.err) model2[int'(addr)] = wdata;
        end
        if (glitch) begin
            @(negedge clk);
            checkOutput("dut2ReadyWait1", 32'(ready2), 32'd0);
            req2 = 1'b1; we2 = 1'b1; addr2 = 16'h0010; wdata2 = 16'hDEAD;
            @(negedge clk);
            checkOutput("dut2ReadyWait2", 32'(ready2), 32'd0);
            @(negedge clk);
            checkOutput("dut2ReadyResp", 32'(ready2), 32'd0);
            req2 = 1'b0;
        end
        if (abandon) begin
            @(negedge clk);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("abandonAck", 32'(ack2), 32'd0);
            checkOutput("abandonReady", 32'(ready2), 32'd1);
            checkOutput("abandonErr", 32'(err2), 32'd0);
            checkOutput("abandonRdata", 32'(rdata2), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        int waitCnt;
        int r;
        logic [15:0] a;

        // Reset both instances and check the idle state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetReady2", 32'(ready2), 32'd1);
        checkOutput("resetAck2", 32'(ack2), 32'd0);
        checkOutput("resetErr2", 32'(err2), 32'd0);
        checkOutput("resetRdata2", 32'(rdata2), 32'd0);
        checkOutput("resetReady0", 32'(ready0), 32'd1);
        checkOutput("resetAck0", 32'(ack0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Store then read back, misaligned accesses, range edges.
        applyStimulus(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0011, 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0200, 16'h5A5A, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h01FE, 16'hA5A5, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h01FE, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Ignored request during the busy window; 0x0010 must stay 0xBEEF.
        applyStimulus(1'b1, 16'h0030, 16'h7777, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0);

        // Store overwritten twice, last write wins.
        applyStimulus(1'b1, 16'h0032, 16'h1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0032, 16'h2222, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0032, 16'h0000, 1'b0, 1'b0);

        // Reset during WAIT abandons the store.
        applyStimulus(1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0020, 16'h5555, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);

        // Random traffic, biased toward a small address pool for reuse.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       a = 16'h0100 + 16'(2 * $urandom_range(0, 7));
            else if (r < 8)  a = 16'(2 * $urandom_range(0, DEPTH - 1));
            else if (r == 8) a = 16'(2 * $urandom_range(0, DEPTH - 1) + 1);
            else             a = 16'(2 * $urandom_range(DEPTH, 32767));
            applyStimulus(1'($urandom), a, 16'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
        end

        // Drain dut2.
        waitCnt = 0;
        while (q2.size() != 0 && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("dut2Drained", 32'(q2.size()), 32'd0);

        // dut0: request held high for six cycles, alternating store/load.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checkOutput("dut0Ready", 32'(ready0), 32'((i % 2) == 0));
            req0   = 1'b1;
            we0    = ((i / 2) % 2) == 0;
            addr0  = 16'h0040 + 16'(2 * (i / 4));
            wdata0 = 16'h1111 * 16'(i / 2 + 1);
            @(posedge clk);
            #1;
            if ((i % 2) == 0) begin
                q0.push_back(predict(we0, addr0, wdata0, cycleCount, 1'b1));
                if (we0 && !modelErr(addr0)) model0[int'(addr0)] = wdata0;
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("dut0AckCount", 32'(acks0), 32'd3);
        checkOutput("dut0Drained", 32'(q0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got 0x1, expected 0x0");
        $fatal(1, "[TB] timeout");
    end

endmodule
